// File: rtl/mem_access_arbiter_pkg.sv
// Shared FSM state encodings, fault codes and small helpers for the memory access arbiter.
package mem_access_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XLATE = 2'd1;
  localparam logic [1:0] ST_BUS   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADDR = 2'b01;
  localparam logic [1:0] EXC_TLB  = 2'b10;
  localparam logic [1:0] EXC_BUS  = 2'b11;

  // User code may not touch the upper half of the address space.
  function automatic logic addr_fault(input logic user_mode, input logic [31:0] vaddr);
    return user_mode & vaddr[31];
  endfunction

endpackage

// File: rtl/mem_access_arbiter_select.sv
// Grant selection between fetch (i) and data (d) requesters.
// MEM_ARB_ROUND_ROBIN_EN: alternate on contention; otherwise d always wins.
module mem_arb_select (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  input  logic take,
  output logic grant_valid,
  output logic grant_d
);

  assign grant_valid = i_req | d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_d = 1 means d has priority on the next contended grant.
  logic rr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_d <= 1'b1;
    end else if (take && grant_valid) begin
      rr_d <= ~grant_d;
    end
  end

  assign grant_d = d_req & (~i_req | rr_d);
`else
  logic unused_rr;
  assign unused_rr = &{1'b0, clk, rst, take};
  assign grant_d   = d_req;
`endif

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares translation and bus port between fetch and data requesters: IDLE -> XLATE -> BUS -> DONE.
// Arbitration policy selected by MEM_ARB_ROUND_ROBIN_EN inside mem_arb_select.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        user_mode,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic [1:0]  i_exc,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [1:0]  d_exc,
  output logic        map_en,
  output logic [31:0] map_vaddr,
  input  logic [31:0] map_paddr,
  input  logic        map_using_tlb,
  input  logic        map_uncached,
  input  logic [31:0] tlb_paddr,
  input  logic        tlb_miss,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_uncached,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [1:0]  state;
  logic        owner_d;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] paddr_q;
  logic        unc_q;
  logic [1:0]  exc_q;
  logic [7:0]  tmo_cnt;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;
  logic        grant_valid;
  logic        grant_d;

  mem_arb_select u_select (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .d_req       (d_req),
    .take        (state == ST_IDLE),
    .grant_valid (grant_valid),
    .grant_d     (grant_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner_d   <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      paddr_q   <= '0;
      unc_q     <= 1'b0;
      exc_q     <= EXC_NONE;
      tmo_cnt   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            // Fetches are always full-word reads.
            owner_d <= grant_d;
            we_q    <= grant_d & d_we;
            be_q    <= grant_d ? d_be : 4'hF;
            addr_q  <= grant_d ? d_addr : i_addr;
            wdata_q <= grant_d ? d_wdata : 32'h0;
            exc_q   <= EXC_NONE;
            state   <= ST_XLATE;
          end
        end
        ST_XLATE: begin
          tmo_cnt <= '0;
          if (addr_fault(user_mode, addr_q)) begin
            exc_q <= EXC_ADDR;
            state <= ST_DONE;
          end else if (map_using_tlb && tlb_miss) begin
            exc_q <= EXC_TLB;
            state <= ST_DONE;
          end else begin
            paddr_q <= map_using_tlb ? tlb_paddr : map_paddr;
            unc_q   <= map_uncached;
            state   <= ST_BUS;
          end
        end
        ST_BUS: begin
          // An ack in the final allowed cycle still counts as success.
          if (bus_ack) begin
            exc_q <= EXC_NONE;
            if (owner_d) d_rdata_q <= bus_rdata;
            else         i_rdata_q <= bus_rdata;
            state <= ST_DONE;
          end else if (tmo_cnt == TMO_LIMIT) begin
            exc_q <= EXC_BUS;
            state <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          tmo_cnt <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign map_en       = (state == ST_XLATE);
  assign map_vaddr    = map_en ? addr_q : 32'h0;

  assign bus_req      = (state == ST_BUS);
  assign bus_we       = we_q;
  assign bus_be       = be_q;
  assign bus_addr     = paddr_q;
  assign bus_wdata    = wdata_q;
  assign bus_uncached = unc_q;

  assign i_done  = (state == ST_DONE) & ~owner_d;
  assign d_done  = (state == ST_DONE) &  owner_d;
  assign i_exc   = i_done ? exc_q : EXC_NONE;
  assign d_exc   = d_done ? exc_q : EXC_NONE;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule
